mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/lion_mem_pkg.sv | 20 ++
 rtl/mem_rr_pick.sv | 22 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lion_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the arbiter state encoding and the default stall limit.
package lion_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   localparam int unsigned WAIT_LIMIT_DEFAULT = 16;

   // Wait counter is at least 5 bits and wide enough to hold WAIT_LIMIT itself.
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 32'd1);
      return (w > 32'd5) ? w : 32'd5;
   endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-requester arbitration decision: fixed data priority or alternating
// between instruction and data based on who was served last.
module mem_rr_pick (
   input  logic       i_req_i,
   input  logic       i_req_d,
   input  logic       i_data_prio,
   input  logic       i_last_d,
   output logic [1:0] o_gnt        // [0] = instruction, [1] = data
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_req_i && i_req_d) begin
         o_gnt = (i_data_prio || !i_last_d) ? 2'b10 : 2'b01;
      end else if (i_req_d) begin
         o_gnt = 2'b10;
      end else if (i_req_i) begin
         o_gnt = 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between an instruction-fetch port and a data port,
// with a sticky timeout flag for transfers that stall too long.
module mem_port_arbiter
   import lion_mem_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT,
   parameter int unsigned DATA_PRIO  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        timeout
);

   localparam int unsigned CW      = cnt_width(WAIT_LIMIT);
   localparam logic [CW-1:0] LIMIT_V = CW'(WAIT_LIMIT);

   arb_state_t    r_state;
   arb_state_t    w_state_next;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic [31:0]   r_i_rdata;
   logic [31:0]   r_d_rdata;
   logic          r_last_d;
   logic          r_timeout;
   logic [CW-1:0] r_wait;
   logic [CW-1:0] w_wait_next;
   logic [1:0]    w_gnt;
   logic          w_prio;

   assign w_prio = (DATA_PRIO != 0);

   mem_rr_pick u_pick (
      .i_req_i     (i_valid),
      .i_req_d     (d_valid),
      .i_data_prio (w_prio),
      .i_last_d    (r_last_d),
      .o_gnt       (w_gnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_gnt[1])      w_state_next = GNT_D;
            else if (w_gnt[0]) w_state_next = GNT_I;
         end
         GNT_I, GNT_D: begin
            if (mem_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_wait_next = (r_wait == '1) ? r_wait : r_wait + CW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_last_d  <= 1'b0;
         r_wait    <= '0;
         r_timeout <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (r_state == IDLE) begin
            if (w_gnt[1]) begin
               r_addr   <= d_addr;
               r_wdata  <= d_wdata;
               r_wstrb  <= d_wstrb;
               r_last_d <= 1'b1;
               r_wait   <= '0;
            end else if (w_gnt[0]) begin
               r_addr   <= i_addr;
               r_wdata  <= '0;
               r_wstrb  <= '0;
               r_last_d <= 1'b0;
               r_wait   <= '0;
            end
         end else if (!mem_ready) begin
            r_wait <= w_wait_next;
            // Flag only; the stalled transfer keeps waiting for mem_ready.
            if (w_wait_next >= LIMIT_V) r_timeout <= 1'b1;
         end
         if (i_ready) r_i_rdata <= mem_rdata;
         if (d_ready) r_d_rdata <= mem_rdata;
      end
   end

   assign mem_valid = (r_state != IDLE);
   assign mem_instr = (r_state == GNT_I);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign i_ready   = (r_state == GNT_I) && mem_ready;
   assign d_ready   = (r_state == GNT_D) && mem_ready;
   assign i_rdata   = i_ready ? mem_rdata : r_i_rdata;
   assign d_rdata   = d_ready ? mem_rdata : r_d_rdata;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and data-priority instances share
// stimulus and are checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0, d_valid = 1'b0, mem_ready = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic [3:0]  d_wstrb = '0;

   logic [1:0]  ir, dr, mv, mi, to;
   logic [31:0] ird [2];
   logic [31:0] drd [2];
   logic [31:0] ma  [2];
   logic [31:0] mwd [2];
   logic [3:0]  mws [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.DATA_PRIO(0)) u_dut_rr (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_ready(ir[0]), .i_addr(i_addr), .i_rdata(ird[0]),
      .d_valid(d_valid), .d_ready(dr[0]), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(drd[0]),
      .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]),
      .mem_wstrb(mws[0]), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout(to[0])
   );

   mem_port_arbiter #(.DATA_PRIO(1)) u_dut_dp (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_ready(ir[1]), .i_addr(i_addr), .i_rdata(ird[1]),
      .d_valid(d_valid), .d_ready(dr[1]), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(drd[1]),
      .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]),
      .mem_wstrb(mws[1]), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout(to[1])
   );

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d]: got %h expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Transaction model: owner 0 = no transfer, 1 = fetch, 2 = data access
   int          m_owner [2] = '{0, 0};
   logic [31:0] m_addr  [2] = '{32'h0, 32'h0};
   logic [31:0] m_wdata [2] = '{32'h0, 32'h0};
   logic [3:0]  m_wstrb [2] = '{4'h0, 4'h0};
   logic [31:0] m_ird   [2] = '{32'h0, 32'h0};
   logic [31:0] m_drd   [2] = '{32'h0, 32'h0};
   bit          m_last_d[2] = '{1'b0, 1'b0};
   int          m_stall [2] = '{0, 0};
   bit          m_to    [2] = '{1'b0, 1'b0};
   bit          take_d;

   always @(posedge clock or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_owner[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
            m_ird[k] = '0; m_drd[k] = '0; m_last_d[k] = 1'b0; m_stall[k] = 0; m_to[k] = 1'b0;
         end else if (m_owner[k] != 0) begin
            if (mem_ready) begin
               if (m_owner[k] == 1) m_ird[k] = mem_rdata;
               else                 m_drd[k] = mem_rdata;
               m_owner[k] = 0;
            end else begin
               m_stall[k]++;
               if (m_stall[k] >= 16) m_to[k] = 1'b1;
            end
         end else if (i_valid || d_valid) begin
            // dut1 always prefers data; dut0 alternates, preferring whoever was not last
            take_d = d_valid && (!i_valid || k == 1 || !m_last_d[k]);
            m_stall[k]  = 0;
            m_last_d[k] = take_d;
            if (take_d) begin
               m_owner[k] = 2; m_addr[k] = d_addr; m_wdata[k] = d_wdata; m_wstrb[k] = d_wstrb;
            end else begin
               m_owner[k] = 1; m_addr[k] = i_addr; m_wdata[k] = '0; m_wstrb[k] = '0;
            end
         end
      end
   end

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         chk("mem_valid", k, mv[k], m_owner[k] != 0);
         chk("mem_instr", k, mi[k], m_owner[k] == 1);
         chk("i_ready", k, ir[k], (m_owner[k] == 1) && mem_ready);
         chk("d_ready", k, dr[k], (m_owner[k] == 2) && mem_ready);
         chk("i_rdata", k, ird[k], ((m_owner[k] == 1) && mem_ready) ? mem_rdata : m_ird[k]);
         chk("d_rdata", k, drd[k], ((m_owner[k] == 2) && mem_ready) ? mem_rdata : m_drd[k]);
         chk("timeout", k, to[k], m_to[k]);
         if (m_owner[k] != 0 || reset) begin
            chk("mem_addr", k, ma[k], m_addr[k]);
            chk("mem_wdata", k, mwd[k], m_wdata[k]);
            chk("mem_wstrb", k, mws[k], m_wstrb[k]);
         end
      end
   end

   bit log_en = 1'b0;
   bit q_rr[$];
   bit q_dp[$];
   int d_pulses = 0;

   always @(negedge clock) begin
      if (log_en && mv[0]) q_rr.push_back(mi[0]);
      if (log_en && mv[1]) q_dp.push_back(mi[1]);
   end

   initial begin
      bit exp_rr [4];
      exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("rst_mem_valid", k, mv[k], 0);
         chk("rst_mem_addr", k, ma[k], 0);
         chk("rst_i_rdata", k, ird[k], 0);
         chk("rst_timeout", k, to[k], 0);
      end

      // Single fetch completing on its first bus cycle
      tick();
      i_valid = 1'b1; i_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
      @(negedge clock);
      for (int k = 0; k < 2; k++) chk("fetch_latency", k, mv[k], 0);
      tick();
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("fetch_valid", k, mv[k], 1);
         chk("fetch_instr", k, mi[k], 1);
         chk("fetch_addr", k, ma[k], 32'h100);
         chk("fetch_wstrb", k, mws[k], 0);
         chk("fetch_ready", k, ir[k], 1);
         chk("fetch_rdata", k, ird[k], 32'h1122_3344);
         chk("fetch_dready", k, dr[k], 0);
      end
      tick();
      i_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("fetch_idle", k, mv[k], 0);
         chk("fetch_rdata_hold", k, ird[k], 32'h1122_3344);
      end

      // Data write stalled three cycles
      tick();
      d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      mem_rdata = 32'h5555_AAAA;
      tick();
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ready = 1'b1;
         @(negedge clock);
         if (dr[1]) d_pulses++;
         for (int k = 0; k < 2; k++) begin
            chk("wr_valid", k, mv[k], 1);
            chk("wr_instr", k, mi[k], 0);
            chk("wr_addr", k, ma[k], 32'h2000);
            chk("wr_wdata", k, mwd[k], 32'hDEAD_BEEF);
            chk("wr_wstrb", k, mws[k], 4'hF);
            chk("wr_dready", k, dr[k], (c == 3) ? 1 : 0);
         end
         tick();
      end
      d_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clock);
      if (dr[1]) d_pulses++;
      chk("wr_pulses", 1, d_pulses, 1);
      for (int k = 0; k < 2; k++) begin
         chk("wr_idle", k, mv[k], 0);
         chk("wr_rdata_hold", k, drd[k], 32'h5555_AAAA);
      end

      // Contention with both requests held; each DUT starts from reset
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h300; d_addr = 32'h400;
      d_wdata = 32'h77; d_wstrb = 4'h0; mem_ready = 1'b1;
      log_en = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         mem_rdata = 32'hA000_0000 + 32'(c);
         tick();
      end
      i_valid = 1'b0; d_valid = 1'b0;
      @(negedge clock);
      log_en = 1'b0;
      chk("rr_count", 0, q_rr.size(), 4);
      chk("dp_count", 1, q_dp.size(), 4);
      for (int g = 0; g < 4; g++) begin
         if (g < q_rr.size()) chk("rr_order", 0, q_rr[g], exp_rr[g]);
         if (g < q_dp.size()) chk("dp_order", 1, q_dp[g], 0);
      end

      // Stall past the limit; timeout must stick after completion
      tick();
      d_valid = 1'b1; d_addr = 32'h500; mem_ready = 1'b0;
      tick();
      for (int c = 1; c <= 16; c++) begin
         @(negedge clock);
         for (int k = 0; k < 2; k++) chk("to_early", k, to[k], 0);
         tick();
      end
      mem_ready = 1'b1;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("to_set", k, to[k], 1);
         chk("to_dready", k, dr[k], 1);
      end
      tick();
      d_valid = 1'b0; mem_ready = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) chk("to_sticky", k, to[k], 1);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) chk("to_rst_clear", k, to[k], 0);
      tick();
      reset = 1'b0;

      // Reset in the middle of a data transfer
      tick();
      d_valid = 1'b1; d_addr = 32'h600; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
      tick();
      @(negedge clock);
      for (int k = 0; k < 2; k++) chk("mid_valid", k, mv[k], 1);
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) chk("mid_rst_valid", k, mv[k], 0);
      mem_ready = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("mid_rst_dready", k, dr[k], 0);
         chk("mid_rst_addr", k, ma[k], 0);
         chk("mid_rst_wstrb", k, mws[k], 0);
      end
      tick();
      reset = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
      tick();
      @(negedge clock);
      for (int k = 0; k < 2; k++) chk("mid_idle", k, mv[k], 0);
      tick();
      d_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("reissue_dready", k, dr[k], 1);
         chk("reissue_addr", k, ma[k], 32'h600);
      end
      tick();
      d_valid = 1'b0; mem_ready = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
